// File: rtl/mem_responder.sv
// Word-addressed memory responder for the MAR/MDR port: wait states, one-cycle ready pulse.
// Optional out-of-range error reporting is compiled in with `define MEM_ERR_EN.
module mem_responder #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 512,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] m_data_in,
    output logic              ready,
    output logic              busy
`ifdef MEM_ERR_EN
    ,
    output logic              mem_err
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(32'hDEADBEEF);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_reg;
    logic [3:0]        count_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wr_data_reg;
    logic              op_write_reg;
    logic [IDX_W-1:0]  idx;
    logic              mem_we;

    logic [DATA_W-1:0] mem [DEPTH];

    // Out-of-range addresses wrap onto the implemented words (DEPTH is a power of two).
    assign idx = addr_reg[IDX_W-1:0];

`ifdef MEM_ERR_EN
    logic err_reg;
    logic out_of_range;

    assign out_of_range = {1'b0, addr} >= (ADDR_W+1)'(DEPTH);
`endif

    always_comb begin
        mem_we = (state_reg == S_DONE) && op_write_reg;
`ifdef MEM_ERR_EN
        if (err_reg) begin
            mem_we = 1'b0;
        end
`endif
    end

    // Array has no reset so it maps onto block RAM; an async reset drops state to IDLE,
    // which also removes the write enable of an aborted transaction.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= wr_data_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            count_reg    <= 4'd0;
            addr_reg     <= '0;
            wr_data_reg  <= '0;
            op_write_reg <= 1'b0;
            m_data_in    <= '0;
            ready        <= 1'b0;
            busy         <= 1'b0;
`ifdef MEM_ERR_EN
            err_reg      <= 1'b0;
            mem_err      <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    ready <= 1'b0;
                    busy  <= read | write;
`ifdef MEM_ERR_EN
                    mem_err <= 1'b0;
`endif
                    if (read | write) begin
                        addr_reg     <= addr;
                        wr_data_reg  <= wr_data;
                        op_write_reg <= write;
                        count_reg    <= 4'(WAIT_STATES);
`ifdef MEM_ERR_EN
                        err_reg      <= out_of_range;
`endif
                        // WAIT always spends one cycle past the countdown, giving a
                        // fixed accept-to-ready latency of WAIT_STATES+2 edges.
                        state_reg    <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (count_reg == 4'd0) begin
                        state_reg <= S_DONE;
                    end else begin
                        count_reg <= count_reg - 4'd1;
                    end
                end

                S_DONE: begin
                    ready     <= 1'b1;
                    state_reg <= S_IDLE;
                    if (!op_write_reg) begin
`ifdef MEM_ERR_EN
                        m_data_in <= err_reg ? ERR_WORD : mem[idx];
`else
                        m_data_in <= mem[idx];
`endif
                    end
`ifdef MEM_ERR_EN
                    mem_err <= err_reg;
`endif
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: scoreboard queue of expected read data, latency checks.
// Instantiated with DEPTH=256 so that address wrap / range errors can be exercised.
module tb_mem_responder;

    localparam int AW  = 9;
    localparam int DW  = 32;
    localparam int DEP = 256;
    localparam int WS  = 2;
    localparam int LAT = WS + 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] m_data_in;
    logic          ready;
    logic          busy;
`ifdef MEM_ERR_EN
    logic          mem_err;
`endif

    int checks = 0;
    int failures = 0;
    int n_edges = 0;
    int rdy_seen = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model [DEP];
    bit cur_read;
    bit cur_err;

    always #5 clk = ~clk;

    mem_responder #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .DEPTH(DEP),
        .WAIT_STATES(WS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .read(read),
        .write(write),
        .addr(addr),
        .wr_data(wr_data),
        .m_data_in(m_data_in),
        .ready(ready),
        .busy(busy)
`ifdef MEM_ERR_EN
        ,
        .mem_err(mem_err)
`endif
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a request and return just after its accept edge.
    task automatic issue(input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit commit);
        @(negedge clk);
        read = rd;
        write = wr;
        addr = a;
        wr_data = d;
        cur_read = rd && !wr;
        cur_err = 1'b0;
`ifdef MEM_ERR_EN
        cur_err = (int'(a) >= DEP);
`endif
        if (cur_read) begin
            exp_q.push_back(cur_err ? 32'hDEADBEEF : model[int'(a) % DEP]);
        end else if (commit && !cur_err) begin
            model[int'(a) % DEP] = d;
        end
        @(posedge clk);
        #1;
        n_edges = 0;
    endtask

    // Wait (bounded) for ready, drop the request, then check completion.
    task automatic complete(input string tag);
        while (n_edges < 20) begin
            @(posedge clk);
            n_edges++;
            #1;
            if (ready === 1'b1) break;
        end
        read = 1'b0;
        write = 1'b0;
        $display("txn %s: ready after %0d edges, m_data_in=%h", tag, n_edges, m_data_in);
        chk({tag, "_latency"}, n_edges, LAT);
        chk({tag, "_busy_at_ready"}, busy, 1);
`ifdef MEM_ERR_EN
        chk({tag, "_mem_err"}, mem_err, cur_err);
`endif
        if (cur_read) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_scoreboard_empty"}, 1, 0);
            end else begin
                chk({tag, "_data"}, m_data_in, exp_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
        chk({tag, "_ready_drop"}, ready, 0);
        chk({tag, "_busy_drop"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset then idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_m_data_in", m_data_in, 0);
            chk("idle_ready", ready, 0);
            chk("idle_busy", busy, 0);
        end

        // 2: write then read same address
        issue(1'b0, 1'b1, 9'h010, 32'h00000024, 1'b1);
        complete("t2_write");
        issue(1'b1, 1'b0, 9'h010, 32'h0, 1'b1);
        complete("t2_read");

        // 3: read and write together -> write wins
        issue(1'b1, 1'b1, 9'h020, 32'h79200000, 1'b1);
        complete("t3_both");
        issue(1'b1, 1'b0, 9'h020, 32'h0, 1'b1);
        complete("t3_read");

        // 4: changes during WAIT are ignored
        issue(1'b0, 1'b1, 9'h030, 32'h00000055, 1'b1);
        complete("t4_prep");
        issue(1'b1, 1'b0, 9'h010, 32'h0, 1'b1);
        read = 1'b0;
        write = 1'b1;
        addr = 9'h030;
        wr_data = 32'hFFFF0000;
        @(posedge clk);
        n_edges++;
        #1;
        write = 1'b0;
        addr = 9'h010;
        complete("t4_read");
        issue(1'b1, 1'b0, 9'h030, 32'h0, 1'b1);
        complete("t4_check030");

        // 5: reset during WAIT of a write aborts it
        issue(1'b0, 1'b1, 9'h040, 32'h00001234, 1'b1);
        complete("t5_prep");
        issue(1'b1, 1'b0, 9'h040, 32'h0, 1'b1);
        complete("t5_prep_read");
        issue(1'b0, 1'b1, 9'h040, 32'h00000BAD, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        write = 1'b0;
        #1;
        chk("t5_reset_ready", ready, 0);
        chk("t5_reset_busy", busy, 0);
        chk("t5_reset_m_data_in", m_data_in, 0);
        rdy_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) rdy_seen++;
        end
        chk("t5_no_ready", rdy_seen, 0);
        @(negedge clk);
        reset = 1'b0;
        issue(1'b1, 1'b0, 9'h040, 32'h0, 1'b1);
        complete("t5_read_back");

        // 6: out-of-range addresses (wrap by default, error with MEM_ERR_EN)
        issue(1'b0, 1'b1, 9'h000, 32'h00000011, 1'b1);
        complete("t6_prep");
        issue(1'b0, 1'b1, 9'h100, 32'h0000A5A5, 1'b1);
        complete("t6_write_hi");
        issue(1'b1, 1'b0, 9'h000, 32'h0, 1'b1);
        complete("t6_read_0");
`ifdef MEM_ERR_EN
        issue(1'b1, 1'b0, 9'h1FF, 32'h0, 1'b1);
        complete("t6_read_1ff");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
